// File: rtl/deflect_port_allocator_pkg.sv
// Shared widths, port ids and flit layout for the deflection router's port allocation stage.
// Also holds the single-flit port selection helper used by every stage of the priority chain.
package deflect_port_allocator_pkg;

    localparam int COORDINATE_SIZE  = 4;
    localparam int PKTID_SIZE       = 4;
    localparam int CHANNEL_SIZE     = 16;
    localparam int PORT_TAG_SIZE    = 3;
    localparam int PROD_VECTOR_SIZE = 5;
    localparam int IN_ROUTER_SIZE   = 2 + PORT_TAG_SIZE + PROD_VECTOR_SIZE + CHANNEL_SIZE;
    localparam int GOLDEN_SIZE      = COORDINATE_SIZE + PKTID_SIZE;
    localparam int NUM_NET          = 4;
    localparam int NUM_PORTS        = 5;

    typedef enum logic [2:0] {
        PORT_E = 3'd0,
        PORT_W = 3'd1,
        PORT_N = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef logic [PROD_VECTOR_SIZE-1:0] port_vec_t;

    localparam port_vec_t NET_PORTS = 5'b01111;

    typedef struct packed {
        logic                        valid;
        logic                        golden;
        logic [PORT_TAG_SIZE-1:0]    port_index;
        port_vec_t                   prod_vec;
        logic [CHANNEL_SIZE-1:0]     flit;
    } in_flit_t;

    typedef struct packed {
        port_vec_t grant;
        logic      deflect;
    } alloc_t;

    // Lowest free productive port, else lowest free network port (a deflection).
    function automatic alloc_t alloc_port(input port_vec_t prod_vec, input port_vec_t free);
        alloc_t    r;
        port_vec_t cand;
        r    = '0;
        cand = prod_vec & free;
        if (cand == '0) begin
            cand      = free & NET_PORTS;
            r.deflect = |cand;
        end
        r.grant = cand & (~cand + 5'd1);
        return r;
    endfunction

endpackage

// File: rtl/deflect_port_allocator_golden_epoch_counter.sv
// Golden epoch timer: holds each golden {coordinate,pktID} for GOLDEN_EPOCH cycles,
// then advances it as a single binary number that wraps from all-ones to zero.
module golden_epoch_counter
    import deflect_port_allocator_pkg::*;
#(
    parameter int GOLDEN_EPOCH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [GOLDEN_SIZE-1:0] counter_golden
);

    localparam int                 EPOCH_W    = (GOLDEN_EPOCH > 2) ? $clog2(GOLDEN_EPOCH) : 1;
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(GOLDEN_EPOCH - 1);

    logic [EPOCH_W-1:0] epoch_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epoch_cnt      <= '0;
            counter_golden <= '0;
        end else if (epoch_cnt == EPOCH_LAST) begin
            epoch_cnt      <= '0;
            counter_golden <= counter_golden + GOLDEN_SIZE'(1);
        end else begin
            epoch_cnt      <= epoch_cnt + EPOCH_W'(1);
        end
    end

endmodule

// File: rtl/deflect_port_allocator.sv
// Bufferless deflection port allocator: ranks up to four network flits plus one injection,
// gives each a distinct output port (deflecting when needed) and registers the result.
module deflect_port_allocator
    import deflect_port_allocator_pkg::*;
#(
    parameter int GOLDEN_EPOCH = 64,
    parameter int DEFL_CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_ROUTER_SIZE-1:0] in_e,
    input  logic [IN_ROUTER_SIZE-1:0] in_w,
    input  logic [IN_ROUTER_SIZE-1:0] in_n,
    input  logic [IN_ROUTER_SIZE-1:0] in_s,
    input  logic [IN_ROUTER_SIZE-1:0] in_inj,
    output logic                      inj_ack,
    output logic [CHANNEL_SIZE-1:0]   out_e,
    output logic [CHANNEL_SIZE-1:0]   out_w,
    output logic [CHANNEL_SIZE-1:0]   out_n,
    output logic [CHANNEL_SIZE-1:0]   out_s,
    output logic [CHANNEL_SIZE-1:0]   out_eject,
    output logic [GOLDEN_SIZE-1:0]    counter_golden,
    output logic [DEFL_CNT_W-1:0]     defl_count
);

    in_flit_t                net [NUM_NET];
    in_flit_t                inj;
    port_vec_t               grant_net [NUM_NET];
    port_vec_t               grant_inj;
    logic [2:0]              tally;
    logic                    any_valid;
    logic [1:0]              rr_ptr;
    logic [CHANNEL_SIZE-1:0] out_next [NUM_PORTS];
    logic [CHANNEL_SIZE-1:0] out_q    [NUM_PORTS];
    logic [DEFL_CNT_W:0]     defl_sum;

    assign net[PORT_E] = in_e;
    assign net[PORT_W] = in_w;
    assign net[PORT_N] = in_n;
    assign net[PORT_S] = in_s;
    assign inj         = in_inj;

    // Port tags belong to route computation; this stage only forwards the flit payload.
    logic unused_port_tags;
    assign unused_port_tags = ^{net[0].port_index, net[1].port_index, net[2].port_index,
                                net[3].port_index, inj.port_index};

    // Priority chain: golden flits, then the rest from rr_ptr onward, then the injection.
    always_comb begin : allocate
        port_vec_t  free;
        alloc_t     a;
        logic [1:0] idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        free      = '1;
        a         = '0;
        idx       = '0;
        tally     = '0;
        any_valid = 1'b0;
        grant_inj = '0;
        for (int i = 0; i < NUM_NET; i++) begin
            grant_net[i] = '0;
            any_valid    = any_valid | net[i].valid;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_NET; k++) begin
                idx = rr_ptr + k[1:0];
                if (net[idx].valid && (net[idx].golden == (pass == 0))) begin
                    a              = alloc_port(net[idx].prod_vec, free);
                    grant_net[idx] = a.grant;
                    free           = free & ~a.grant;
                    tally          = tally + {2'b00, a.deflect};
                end
            end
        end
        if (inj.valid) begin
            a         = alloc_port(inj.prod_vec, free);
            grant_inj = a.grant;
            tally     = tally + {2'b00, a.deflect};
        end
    end

    assign inj_ack = (|grant_inj) & reset;

    always_comb begin : route
        for (int p = 0; p < NUM_PORTS; p++) begin
            out_next[p] = '0;
            for (int i = 0; i < NUM_NET; i++) begin
                if (grant_net[i][p]) out_next[p] = net[i].flit;
            end
            if (grant_inj[p]) out_next[p] = inj.flit;
        end
    end

    assign defl_sum = {1'b0, defl_count} + (DEFL_CNT_W + 1)'(tally);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= '0;
            rr_ptr     <= '0;
            defl_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= out_next[p];
            if (any_valid) rr_ptr <= rr_ptr + 2'd1;
            defl_count <= defl_sum[DEFL_CNT_W] ? '1 : defl_sum[DEFL_CNT_W-1:0];
        end
    end

    assign out_e     = out_q[PORT_E];
    assign out_w     = out_q[PORT_W];
    assign out_n     = out_q[PORT_N];
    assign out_s     = out_q[PORT_S];
    assign out_eject = out_q[PORT_L];

    golden_epoch_counter #(
        .GOLDEN_EPOCH (GOLDEN_EPOCH)
    ) u_golden (
        .clk            (clk),
        .reset          (reset),
        .counter_golden (counter_golden)
    );

endmodule

// File: tb/tb_deflect_port_allocator.sv
// Directed bench for deflect_port_allocator: reset, golden epoch, ranking/deflection,
// injection gating, mid-operation reset and deflection counter saturation.
module tb_deflect_port_allocator;
    import deflect_port_allocator_pkg::*;

    localparam int DEFL_CNT_W = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [IN_ROUTER_SIZE-1:0] in_e, in_w, in_n, in_s, in_inj;
    logic                      inj_ack;
    logic [CHANNEL_SIZE-1:0]   out_e, out_w, out_n, out_s, out_eject;
    logic [GOLDEN_SIZE-1:0]    counter_golden;
    logic [DEFL_CNT_W-1:0]     defl_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    deflect_port_allocator #(
        .GOLDEN_EPOCH (64),
        .DEFL_CNT_W   (DEFL_CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_e           (in_e),
        .in_w           (in_w),
        .in_n           (in_n),
        .in_s           (in_s),
        .in_inj         (in_inj),
        .inj_ack        (inj_ack),
        .out_e          (out_e),
        .out_w          (out_w),
        .out_n          (out_n),
        .out_s          (out_s),
        .out_eject      (out_eject),
        .counter_golden (counter_golden),
        .defl_count     (defl_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks = n_checks + 1;
        assert (observed === expected) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [IN_ROUTER_SIZE-1:0] mk(input logic v, input logic g,
                                                     input logic [4:0] pv, input logic [15:0] f);
        in_flit_t t;
        t.valid      = v;
        t.golden     = g;
        t.port_index = '0;
        t.prod_vec   = pv;
        t.flit       = f;
        return t;
    endfunction

    task automatic clear_inputs();
        in_e   = '0;
        in_w   = '0;
        in_n   = '0;
        in_s   = '0;
        in_inj = '0;
    endtask

    task automatic check_links(input string tag, input logic [15:0] e, input logic [15:0] w,
                               input logic [15:0] n, input logic [15:0] s, input logic [15:0] l);
        check({tag, "_e"}, 32'(out_e), 32'(e));
        check({tag, "_w"}, 32'(out_w), 32'(w));
        check({tag, "_n"}, 32'(out_n), 32'(n));
        check({tag, "_s"}, 32'(out_s), 32'(s));
        check({tag, "_eject"}, 32'(out_eject), 32'(l));
    endtask

    initial begin
        // Reset held with random inputs, including a valid injection candidate.
        reset = 1'b0;
        in_e   = IN_ROUTER_SIZE'($urandom);
        in_w   = IN_ROUTER_SIZE'($urandom);
        in_n   = IN_ROUTER_SIZE'($urandom);
        in_s   = IN_ROUTER_SIZE'($urandom);
        in_inj = IN_ROUTER_SIZE'($urandom) | {1'b1, {(IN_ROUTER_SIZE-1){1'b0}}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_links("rst_out", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
            check("rst_inj_ack", 32'(inj_ack), 32'h0);
            check("rst_defl", 32'(defl_count), 32'h0);
            check("rst_golden", 32'(counter_golden), 32'h0);
        end

        // Golden epoch: 0 for 64 cycles, then 1; all-ones wraps to 0.
        clear_inputs();
        reset = 1'b1;
        repeat (63) @(negedge clk);
        check("golden_63", 32'(counter_golden), 32'h0);
        @(negedge clk);
        check("golden_64", 32'(counter_golden), 32'h1);
        repeat (255 * 64 - 64) @(negedge clk);
        check("golden_ones", 32'(counter_golden), 32'hFF);
        repeat (63) @(negedge clk);
        check("golden_ones_end", 32'(counter_golden), 32'hFF);
        @(negedge clk);
        check("golden_wrap", 32'(counter_golden), 32'h0);
        check("idle_defl", 32'(defl_count), 32'h0);
        check_links("idle", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Single productive flit E->N (rr_ptr 0 -> 1).
        in_e = mk(1'b1, 1'b0, 5'b00100, 16'h1234);
        @(negedge clk);
        check_links("single", 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0);
        check("single_defl", 32'(defl_count), 32'h0);

        // Contention for E; golden W wins, E deflects to W (rr_ptr 1 -> 2).
        clear_inputs();
        in_e = mk(1'b1, 1'b0, 5'b00001, 16'hAAAA);
        in_w = mk(1'b1, 1'b1, 5'b00001, 16'hBBBB);
        @(negedge clk);
        check_links("contend", 16'hBBBB, 16'hAAAA, 16'h0, 16'h0, 16'h0);
        check("contend_defl", 32'(defl_count), 32'h1);

        // Two local flits at rr_ptr 2: N ejects, S deflects to E (rr_ptr 2 -> 3).
        clear_inputs();
        in_n = mk(1'b1, 1'b0, 5'b10000, 16'hC0C0);
        in_s = mk(1'b1, 1'b0, 5'b10000, 16'hD0D0);
        @(negedge clk);
        check_links("eject", 16'hD0D0, 16'h0, 16'h0, 16'h0, 16'hC0C0);
        check("eject_defl", 32'(defl_count), 32'h2);

        // Four network flits take all network ports; injection wanting E is refused.
        clear_inputs();
        in_e   = mk(1'b1, 1'b0, 5'b00001, 16'h0E0E);
        in_w   = mk(1'b1, 1'b0, 5'b00010, 16'h0F0F);
        in_n   = mk(1'b1, 1'b0, 5'b00100, 16'h0A0A);
        in_s   = mk(1'b1, 1'b0, 5'b01000, 16'h0B0B);
        in_inj = mk(1'b1, 1'b0, 5'b00001, 16'h9999);
        #1;
        check("block_inj_ack", 32'(inj_ack), 32'h0);
        @(negedge clk);
        check_links("block", 16'h0E0E, 16'h0F0F, 16'h0A0A, 16'h0B0B, 16'h0);
        check("block_defl", 32'(defl_count), 32'h2);

        // Three network flits plus an invalid S carrying junk; injection deflects to S.
        in_s = mk(1'b0, 1'b1, 5'b01000, 16'h5555);
        in_inj = mk(1'b1, 1'b0, 5'b00001, 16'h7777);
        #1;
        check("inj_ack", 32'(inj_ack), 32'h1);
        @(negedge clk);
        check_links("inject", 16'h0E0E, 16'h0F0F, 16'h0A0A, 16'h7777, 16'h0);
        check("inject_defl", 32'(defl_count), 32'h3);

        // Reset mid-operation drops registered flits and gates inj_ack.
        clear_inputs();
        in_e   = mk(1'b1, 1'b0, 5'b00001, 16'h4242);
        in_inj = mk(1'b1, 1'b0, 5'b00010, 16'h2424);
        @(negedge clk);
        check_links("pre_rst", 16'h4242, 16'h2424, 16'h0, 16'h0, 16'h0);
        reset = 1'b0;
        #1;
        check_links("mid_rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check("mid_rst_inj_ack", 32'(inj_ack), 32'h0);
        check("mid_rst_defl", 32'(defl_count), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Four deflections per cycle: three local losers plus an injection pushed to S.
        in_e   = mk(1'b1, 1'b0, 5'b10000, 16'h1111);
        in_w   = mk(1'b1, 1'b0, 5'b10000, 16'h2222);
        in_n   = mk(1'b1, 1'b0, 5'b10000, 16'h3333);
        in_s   = mk(1'b1, 1'b0, 5'b10000, 16'h4444);
        in_inj = mk(1'b1, 1'b0, 5'b00001, 16'h5555);
        #1;
        check("sat_inj_ack", 32'(inj_ack), 32'h1);
        repeat (16383) @(negedge clk);
        check("sat_65532", 32'(defl_count), 32'd65532);

        clear_inputs();
        in_e = mk(1'b1, 1'b0, 5'b00001, 16'h1111);
        in_w = mk(1'b1, 1'b0, 5'b00001, 16'h2222);
        in_n = mk(1'b1, 1'b0, 5'b00001, 16'h3333);
        @(negedge clk);
        check("sat_65534", 32'(defl_count), 32'd65534);

        in_s = mk(1'b1, 1'b0, 5'b00001, 16'h4444);
        @(negedge clk);
        check("sat_max", 32'(defl_count), 32'hFFFF);
        @(negedge clk);
        check("sat_hold", 32'(defl_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
